// File: rtl/long_multiply.sv
// long_multiply: sequential shift-add multiply-accumulate.
//   product = low SIZE bits of (multiplicand * multiplier + addend)
//   error   = the full result needs more than SIZE bits
// Used beside the long divider to rebuild a dividend from
// (divisor, quotient, remainder). The latency is fixed and does not depend
// on the data: a start accepted at edge 0 gives done in the cycle after
// edge SIZE+1.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-low reset
//   start         request an operation; sampled only in IDLE
//   multiplicand  first factor  (SIZE bits)
//   multiplier    second factor (SIZE bits)
//   addend        value added to the product (SIZE bits)
//   busy          high while in RUN or DONE
//   done          one-cycle pulse when product/error become valid
//   error         result overflowed SIZE bits
//   product       low SIZE bits of the result; held until the next start
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; product/error hold the last result
// RUN   | SIZE shift-add iterations, one multiplier bit per cycle
// DONE  | publish acc to product/error, pulse done, return to IDLE
module long_multiply #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] multiplicand,
  input  logic [SIZE-1:0] multiplier,
  input  logic [SIZE-1:0] addend,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [SIZE-1:0] product
);

  localparam int CW = $clog2(SIZE) + 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2*SIZE-1:0] mcand_r;
  logic [2*SIZE-1:0] acc;
  logic [SIZE-1:0]   mplier_r;
  logic [CW-1:0]     count;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (count == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc      <= '0;
      count    <= '0;
      product  <= '0;
      error    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand_r  <= {{SIZE{1'b0}}, multiplicand};
            mplier_r <= multiplier;
            // seeding acc with addend folds the add into the shift-add loop
            acc      <= {{SIZE{1'b0}}, addend};
            count    <= '0;
            product  <= '0;
            error    <= 1'b0;
          end
        end
        RUN: begin
          // max result is below 2^(2*SIZE), so this add never carries out
          if (mplier_r[0]) acc <= acc + mcand_r;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          count    <= count + CW'(1);
        end
        DONE: begin
          product <= acc[SIZE-1:0];
          error   <= |acc[2*SIZE-1:SIZE];
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_long_multiply.sv
// Bench for long_multiply: randomized and directed operations. The driver
// pushes the expected result and expected done cycle into a queue; an
// independent monitor pops and compares whenever done is seen.
module tb_long_multiply;

  localparam int SIZE = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [SIZE-1:0] multiplicand, multiplier, addend;
  logic            busy, done, error;
  logic [SIZE-1:0] product;

  long_multiply #(.SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier), .addend(addend),
    .busy(busy), .done(done), .error(error), .product(product)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [SIZE-1:0] p;
    logic            e;
    int              dc;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("product", 64'(product), 64'(e.p));
        check("error", 64'(error), 64'(e.e));
        check("done_cycle", 64'(cyc), 64'(e.dc));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // Called at a negedge with start about to be sampled on the next posedge.
  task automatic push_exp(input logic [SIZE-1:0] p, input logic e);
    exp_t x;
    x.p  = p;
    x.e  = e;
    x.dc = cyc + SIZE + 2;
    sbq.push_back(x);
  endtask

  task automatic push_model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                            input logic [SIZE-1:0] c);
    logic [2*SIZE-1:0] full;
    full = (2*SIZE)'(a) * (2*SIZE)'(b) + (2*SIZE)'(c);
    push_exp(full[SIZE-1:0], |full[2*SIZE-1:SIZE]);
  endtask

  task automatic wait_not_busy();
    int t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("wait_not_busy_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                       input logic [SIZE-1:0] c, input logic [SIZE-1:0] p, input logic e);
    wait_not_busy();
    multiplicand = a;
    multiplier   = b;
    addend       = c;
    start        = 1'b1;
    push_exp(p, e);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    addend       = $urandom;
  endtask

  task automatic op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                    input logic [SIZE-1:0] c);
    logic [2*SIZE-1:0] full;
    full = (2*SIZE)'(a) * (2*SIZE)'(b) + (2*SIZE)'(c);
    issue(a, b, c, full[SIZE-1:0], |full[2*SIZE-1:SIZE]);
  endtask

  task automatic drain();
    int t = 0;
    while ((sbq.size() != 0 || busy) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() != 0 || busy) check("drain_timeout", 64'(sbq.size()), 64'd0);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_product"}, 64'(product), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
  endtask

  initial begin
    logic [SIZE-1:0] dvd, dvs;
    reset = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    addend       = '0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // basic case, latency checked through the scoreboard's done cycle
    op(32'd6, 32'd7, 32'd5);
    drain();
    check("busy_after_done", 64'(busy), 64'd0);

    // overflow corners
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op(32'h0001_0000, 32'h0001_0000, 32'h0);
    op(32'hFFFF_FFFF, 32'h1, 32'h1);
    op(32'h0, 32'h0, 32'h0);
    op(32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();

    // random operands
    for (int i = 0; i < 40; i++) begin
      case (i % 3)
        0: op($urandom, $urandom, $urandom);
        1: op($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom);
        default: op($urandom, $urandom_range(0, 3), $urandom);
      endcase
    end
    drain();

    // divider cross-check: rebuild dividend from divisor, quotient, remainder
    for (int i = 0; i < 1000; i++) begin
      dvd = $urandom;
      dvs = (i % 2 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (dvs == 0) dvs = 32'd1;
      issue(dvs, dvd / dvs, dvd % dvs, dvd, 1'b0);
    end
    drain();

    // start during RUN is ignored
    op(32'd1234, 32'd5678, 32'd9);
    repeat (4) @(negedge clk);
    multiplicand = 32'd99;
    multiplier   = 32'd98;
    addend       = 32'd97;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    drain();

    // start held high: three back-to-back operations
    for (int k = 0; k < 3; k++) begin
      int t;
      logic [SIZE-1:0] a, b, c;
      a = $urandom;
      b = $urandom;
      c = $urandom;
      multiplicand = a;
      multiplier   = b;
      addend       = c;
      start        = 1'b1;
      push_model(a, b, c);
      if (k < 2) begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (done !== 1'b1 && t < 100);
        if (done !== 1'b1) check("held_start_timeout", 64'd1, 64'd0);
      end
    end
    @(negedge clk);
    start = 1'b0;
    drain();

    // reset mid-RUN aborts the operation without a done pulse
    op(32'hDEAD_BEEF, 32'h1234_5678, 32'h42);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    void'(sbq.pop_back());
    check_idle_zero("abort");
    repeat (SIZE + 5) @(negedge clk);
    op(32'hDEAD_BEEF, 32'h1234_5678, 32'h42);
    drain();
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
